// File: rtl/round_key_store_pkg.sv
// Shared constants, state encoding and byte helpers for the AES-128
// round-key store and the schedule stage it sequences.
package round_key_store_pkg;

   localparam int KEY_W        = 128;
   localparam int NUM_ROUNDS   = 10;
   localparam int FLAG_TIMEOUT = 16;
   localparam logic [7:0] RCON_INIT = 8'h01;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_EXPAND = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   // Multiply by x in GF(2^8); advances the round constant one step.
   function automatic logic [7:0] xtime(input logic [7:0] r);
      return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
   endfunction

   // FIPS byte string (byte 0 leftmost) to row/column state layout,
   // where byte 4*row+col lives at bits [8*(4*row+col)+:8].
   function automatic logic [KEY_W-1:0] to_state(input logic [KEY_W-1:0] fips);
      logic [KEY_W-1:0] s;
      s = '0;
      for (int i = 0; i < 16; i++) begin
         s[8*(4*(i%4) + (i/4)) +: 8] = fips[KEY_W-1-8*i -: 8];
      end
      return s;
   endfunction

endpackage

// File: rtl/round_key_store_if.sv
// Bundle of the store's control, schedule-link and read-port signals.
// The master side is the cipher controller plus the attached schedule;
// the slave side is the round-key store itself.
interface round_key_store_if;
   import round_key_store_pkg::*;

   logic             start;
   logic [KEY_W-1:0] cipher_key_i;
   logic [KEY_W-1:0] ks_key_i;
   logic             ks_flag_i;
   logic             ks_en_o;
   logic [7:0]       ks_rcon_o;
   logic [KEY_W-1:0] ks_key_o;
   logic [3:0]       rd_addr;
   logic [KEY_W-1:0] rd_key;
   logic             keys_ready;
   logic             busy;
   logic             err_o;

   modport master (
      output start, cipher_key_i, ks_key_i, ks_flag_i, rd_addr,
      input  ks_en_o, ks_rcon_o, ks_key_o, rd_key, keys_ready, busy, err_o
   );

   modport slave (
      input  start, cipher_key_i, ks_key_i, ks_flag_i, rd_addr,
      output ks_en_o, ks_rcon_o, ks_key_o, rd_key, keys_ready, busy, err_o
   );

endinterface

// File: rtl/round_key_store.sv
// Sequencer and key RAM around the AES-128 key-schedule stage.
// Loads the cipher key, steps the schedule one round per Key_flag by
// feeding each captured round key back as the next input, and holds all
// round keys for random-access reads by the cipher datapath.
module round_key_store
   import round_key_store_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   round_key_store_if.slave bus
);

   localparam int SLOTS = NUM_ROUNDS + 1;
   localparam int CNT_W = $clog2(FLAG_TIMEOUT);

   state_t           state;
   state_t           next_state;
   logic [3:0]       round;
   logic [CNT_W-1:0] wd_cnt;
   logic [KEY_W-1:0] slot [SLOTS];

   logic             load;
   logic             capture;
   logic             finish;
   logic             timeout;

   logic             en_q;
   logic [7:0]       rcon_q;
   logic [KEY_W-1:0] key_q;
   logic [KEY_W-1:0] rd_q;
   logic             ready_q;
   logic             busy_q;
   logic             err_q;

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next state and one-cycle action strobes; the finishing cycle after the
   // last capture takes priority so a late flag cannot start an extra round.
   always_comb begin
      next_state = state;
      load       = 1'b0;
      capture    = 1'b0;
      finish     = 1'b0;
      timeout    = 1'b0;
      case (state)
         ST_IDLE, ST_DONE: begin
            if (bus.start) begin
               load       = 1'b1;
               next_state = ST_EXPAND;
            end
         end
         ST_EXPAND: begin
            if (round > 4'(NUM_ROUNDS)) begin
               finish     = 1'b1;
               next_state = ST_DONE;
            end else if (bus.ks_flag_i) begin
               capture = 1'b1;
            end else if (wd_cnt == CNT_W'(FLAG_TIMEOUT - 1)) begin
               timeout    = 1'b1;
               next_state = ST_IDLE;
            end
         end
         default: begin
            next_state = ST_IDLE;
         end
      endcase
   end

   // Round index and flag watchdog; both restart on start and each flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         round  <= 4'd0;
         wd_cnt <= '0;
      end else if (load) begin
         round  <= 4'd1;
         wd_cnt <= '0;
      end else if (capture) begin
         round  <= round + 4'd1;
         wd_cnt <= '0;
      end else if (state == ST_EXPAND && !finish && !timeout) begin
         wd_cnt <= wd_cnt + CNT_W'(1);
      end
   end

   // Key RAM: slot 0 takes the cipher key, slot[round] the schedule output.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < SLOTS; i++) begin
            slot[i] <= '0;
         end
      end else begin
         for (int i = 0; i < SLOTS; i++) begin
            if (load) begin
               slot[i] <= (i == 0) ? bus.cipher_key_i : '0;
            end else if (capture && round == 4'(i)) begin
               slot[i] <= bus.ks_key_i;
            end
         end
      end
   end

   // Schedule drive and status flags; the fed-back key and RCON move on the
   // same edge the flag is sampled so the schedule's next round sees them.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         en_q    <= 1'b0;
         rcon_q  <= 8'h00;
         key_q   <= '0;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
      end else if (load) begin
         en_q    <= 1'b1;
         rcon_q  <= RCON_INIT;
         key_q   <= bus.cipher_key_i;
         ready_q <= 1'b0;
         busy_q  <= 1'b1;
         err_q   <= 1'b0;
      end else if (capture) begin
         rcon_q <= xtime(rcon_q);
         key_q  <= bus.ks_key_i;
      end else if (finish) begin
         en_q    <= 1'b0;
         busy_q  <= 1'b0;
         ready_q <= 1'b1;
      end else if (timeout) begin
         en_q   <= 1'b0;
         busy_q <= 1'b0;
         err_q  <= 1'b1;
      end
   end

   // Registered read port; indices past the last round return zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_q <= '0;
      end else if (bus.rd_addr <= 4'(NUM_ROUNDS)) begin
         rd_q <= slot[bus.rd_addr];
      end else begin
         rd_q <= '0;
      end
   end

   assign bus.ks_en_o    = en_q;
   assign bus.ks_rcon_o  = rcon_q;
   assign bus.ks_key_o   = key_q;
   assign bus.rd_key     = rd_q;
   assign bus.keys_ready = ready_q;
   assign bus.busy       = busy_q;
   assign bus.err_o      = err_q;

endmodule

// File: tb/tb_round_key_store.sv
// Testbench for round_key_store: a behavioural AES-128 key schedule with
// random latency answers the store's requests, and a reference expansion
// built from the AES rules supplies every expected round key.
module tb_round_key_store;

   logic clk;
   logic rst;

   round_key_store_if bus();

   round_key_store dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int            n_checks;
   int            n_fail;
   int            flag_cnt;
   bit            sched_on;
   logic [7:0]    rcon_seen [$];
   logic [7:0]    sbox [256];
   logic [127:0]  ref_keys [11];
   logic [7:0]    rcon_tab [10];

   // Count a comparison and report it when observed and expected differ.
   task automatic checkOutput(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
      n_checks++;
      if (observed !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   function automatic logic [7:0] gf_double(input logic [7:0] a);
      logic [8:0] t;
      t = {1'b0, a} * 9'd2;
      return (a >= 8'h80) ? (t[7:0] ^ 8'h1b) : t[7:0];
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] p;
      acc = 8'h00;
      p   = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ p;
         p = gf_double(p);
      end
      return acc;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
      return (v << n) | (v >> (8 - n));
   endfunction

   // S-box from its definition: GF(2^8) inverse followed by the affine map.
   task automatic build_sbox();
      for (int a = 0; a < 256; a++) begin
         logic [7:0] inv;
         inv = 8'h00;
         for (int b = 1; b < 256; b++) begin
            if (gf_mul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
         end
         sbox[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                   ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [127:0] fips_to_state(input logic [127:0] fips);
      logic [127:0] s;
      s = '0;
      for (int i = 0; i < 16; i++) begin
         s[8*(4*(i%4) + (i/4)) +: 8] = fips[127-8*i -: 8];
      end
      return s;
   endfunction

   // One AES-128 key-expansion round, operating on the row/column layout.
   function automatic logic [127:0] expand_key(input logic [127:0] k, input logic [7:0] rc);
      logic [7:0]   b [4][4];
      logic [7:0]   t [4];
      logic [127:0] o;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            b[r][c] = k[8*(4*r+c) +: 8];
      for (int r = 0; r < 4; r++) t[r] = sbox[b[(r+1)%4][3]];
      t[0] = t[0] ^ rc;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            b[r][c] = b[r][c] ^ ((c == 0) ? t[r] : b[r][c-1]);
      o = '0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            o[8*(4*r+c) +: 8] = b[r][c];
      return o;
   endfunction

   task automatic build_ref(input logic [127:0] key);
      ref_keys[0] = key;
      for (int i = 1; i <= 10; i++) ref_keys[i] = expand_key(ref_keys[i-1], rcon_tab[i-1]);
   endtask

   // Behavioural key schedule: answers each enabled round after a random gap.
   initial begin : schedule_model
      int gap;
      gap = 1;
      bus.ks_flag_i = 1'b0;
      bus.ks_key_i  = '0;
      forever begin
         @(posedge clk);
         #1;
         bus.ks_flag_i = 1'b0;
         if (sched_on && bus.ks_en_o && !rst && flag_cnt < 10) begin
            if (gap == 0) begin
               bus.ks_key_i  = expand_key(bus.ks_key_o, bus.ks_rcon_o);
               bus.ks_flag_i = 1'b1;
               rcon_seen.push_back(bus.ks_rcon_o);
               flag_cnt++;
               gap = $urandom_range(3, 0);
            end else begin
               gap--;
            end
         end
      end
   end

   task automatic applyStimulus(input logic [127:0] key);
      flag_cnt = 0;
      rcon_seen.delete();
      bus.cipher_key_i = key;
      bus.start        = 1'b1;
      @(posedge clk);
      #2;
      bus.start = 1'b0;
   endtask

   task automatic readCheck(input logic [3:0] addr, input logic [127:0] exp, input string tag);
      bus.rd_addr = addr;
      @(posedge clk);
      #2;
      checkOutput(tag, bus.rd_key, exp);
   endtask

   task automatic waitFlags(input int n);
      int guard;
      guard = 0;
      while (flag_cnt < n && guard < 200) begin
         @(posedge clk);
         #2;
         guard++;
      end
      if (flag_cnt < n) checkOutput("flag_wait", 128'(flag_cnt), 128'(n));
   endtask

   task automatic waitReady(input int budget, output int cycles);
      cycles = 0;
      while (!bus.keys_ready && cycles < budget) begin
         @(posedge clk);
         #2;
         cycles++;
      end
      if (!bus.keys_ready) checkOutput("ready_wait", 128'(bus.keys_ready), 128'(1));
   endtask

   task automatic verifyAll(input string tag);
      for (int i = 0; i <= 10; i++) readCheck(4'(i), ref_keys[i], tag);
   endtask

   initial begin : main
      logic [127:0] key_a;
      logic [127:0] key_b;
      int           cyc;

      n_checks = 0;
      n_fail   = 0;
      flag_cnt = 0;
      sched_on = 1'b1;
      rcon_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
      build_sbox();

      rst              = 1'b1;
      bus.start        = 1'b0;
      bus.cipher_key_i = '0;
      bus.rd_addr      = 4'd0;
      @(posedge clk);
      #2;
      checkOutput("rst_en",    128'(bus.ks_en_o),    128'(0));
      checkOutput("rst_rcon",  128'(bus.ks_rcon_o),  128'(0));
      checkOutput("rst_key_o", bus.ks_key_o,         '0);
      checkOutput("rst_rd",    bus.rd_key,           '0);
      checkOutput("rst_ready", 128'(bus.keys_ready), 128'(0));
      checkOutput("rst_busy",  128'(bus.busy),       128'(0));
      checkOutput("rst_err",   128'(bus.err_o),      128'(0));
      @(posedge clk);
      #2;
      rst = 1'b0;
      @(posedge clk);
      #2;

      $display("[TB] FIPS-197 key with attached schedule");
      key_a = fips_to_state(128'h2b7e1516_28aed2a6_abf71588_09cf4f3c);
      build_ref(key_a);
      applyStimulus(key_a);
      checkOutput("start_busy", 128'(bus.busy),    128'(1));
      checkOutput("start_en",   128'(bus.ks_en_o), 128'(1));
      waitReady(100, cyc);
      checkOutput("ready_in_100", 128'(cyc <= 100), 128'(1));
      readCheck(4'd1,  fips_to_state(128'ha0fafe17_88542cb1_23a33939_2a6c7605), "fips_round1");
      readCheck(4'd10, fips_to_state(128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6), "fips_round10");
      verifyAll("fips_slots");

      $display("[TB] RCON order and enable fall");
      key_b = {$urandom, $urandom, $urandom, $urandom};
      build_ref(key_b);
      applyStimulus(key_b);
      waitFlags(10);
      @(posedge clk);
      #2;
      checkOutput("en_after_flag10",   128'(bus.ks_en_o),    128'(1));
      @(posedge clk);
      #2;
      checkOutput("en_fall",           128'(bus.ks_en_o),    128'(0));
      checkOutput("busy_fall",         128'(bus.busy),       128'(0));
      checkOutput("ready_rise",        128'(bus.keys_ready), 128'(1));
      checkOutput("rcon_count", 128'(rcon_seen.size()), 128'(10));
      for (int i = 0; i < 10 && i < rcon_seen.size(); i++)
         checkOutput($sformatf("rcon_%0d", i), 128'(rcon_seen[i]), 128'(rcon_tab[i]));
      verifyAll("rand_slots");

      $display("[TB] start during expansion is ignored");
      build_ref(key_a);
      applyStimulus(key_a);
      waitFlags(4);
      bus.cipher_key_i = {$urandom, $urandom, $urandom, $urandom};
      bus.start        = 1'b1;
      @(posedge clk);
      #2;
      bus.start = 1'b0;
      checkOutput("ignored_start_busy", 128'(bus.busy), 128'(1));
      waitReady(200, cyc);
      verifyAll("ignored_start_slots");

      $display("[TB] random keys, reads during expansion");
      for (int n = 0; n < 3; n++) begin
         key_b = {$urandom, $urandom, $urandom, $urandom};
         build_ref(key_b);
         applyStimulus(key_b);
         readCheck(4'd10, '0, "unwritten_slot");
         checkOutput("ready_cleared", 128'(bus.keys_ready), 128'(0));
         waitReady(200, cyc);
         verifyAll($sformatf("rand_key%0d", n));
      end

      $display("[TB] out-of-range reads and read latency in DONE");
      readCheck(4'd11, '0, "rd_addr11");
      readCheck(4'd15, '0, "rd_addr15");
      bus.rd_addr = 4'd0;
      #1;
      checkOutput("rd_latency_hold", bus.rd_key, '0);
      @(posedge clk);
      #2;
      checkOutput("rd_addr0", bus.rd_key, key_b);

      $display("[TB] watchdog timeout");
      sched_on = 1'b0;
      key_a = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus(key_a);
      repeat (10) begin @(posedge clk); #2; end
      checkOutput("wd_err_early",  128'(bus.err_o), 128'(0));
      checkOutput("wd_busy_early", 128'(bus.busy),  128'(1));
      repeat (10) begin @(posedge clk); #2; end
      checkOutput("wd_err",   128'(bus.err_o),      128'(1));
      checkOutput("wd_busy",  128'(bus.busy),       128'(0));
      checkOutput("wd_ready", 128'(bus.keys_ready), 128'(0));
      checkOutput("wd_en",    128'(bus.ks_en_o),    128'(0));
      readCheck(4'd0, key_a, "wd_slot0_kept");
      readCheck(4'd1, '0,    "wd_slot1");
      sched_on = 1'b1;
      build_ref(key_a);
      applyStimulus(key_a);
      checkOutput("wd_err_cleared", 128'(bus.err_o), 128'(0));
      waitReady(200, cyc);
      verifyAll("wd_restart_slots");

      $display("[TB] reset during expansion");
      applyStimulus(key_b);
      waitFlags(3);
      rst = 1'b1;
      #1;
      checkOutput("arst_en",   128'(bus.ks_en_o), 128'(0));
      checkOutput("arst_busy", 128'(bus.busy),    128'(0));
      @(posedge clk);
      #2;
      checkOutput("arst_en_next",   128'(bus.ks_en_o),   128'(0));
      checkOutput("arst_busy_next", 128'(bus.busy),      128'(0));
      checkOutput("arst_rcon",      128'(bus.ks_rcon_o), 128'(0));
      checkOutput("arst_rd",        bus.rd_key,          '0);
      rst = 1'b0;
      readCheck(4'd0, '0, "arst_slot0");
      readCheck(4'd2, '0, "arst_slot2");
      readCheck(4'd3, '0, "arst_slot3");
      checkOutput("arst_ready", 128'(bus.keys_ready), 128'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
